// File: rtl/lix_skid_buf.sv
// Two-entry skid buffer: registered o_rdy, head entry drives o_z, a skid entry
// absorbs the one word that can arrive while downstream stalls.
module lix_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_flush,
    input  logic         i_vld,
    input  logic [W-1:0] i_x,
    output logic         o_rdy,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_z,
    output logic [1:0]   o_occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   main_reg, main_next;
    logic [W-1:0]   skid_reg, skid_next;
    logic           rdy_reg, rdy_next;
    logic           accept;
    logic           xfer;

    assign accept = i_vld & rdy_reg;
    assign xfer   = (state_reg != EMPTY) & i_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            rdy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            rdy_reg   <= rdy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    main_next  = i_x;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (accept && xfer) begin
                    main_next = i_x;
                end else if (accept) begin
                    skid_next  = i_x;
                    state_next = FULL;
                end else if (xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    main_next  = skid_reg;
                    state_next = BUSY;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush drops occupancy only; stored words are left in place.
        if (i_flush) begin
            state_next = EMPTY;
            main_next  = main_reg;
            skid_next  = skid_reg;
        end
        rdy_next = (state_next != FULL);
    end

    assign o_rdy = rdy_reg;
    assign o_vld = (state_reg != EMPTY);
    assign o_z   = main_reg;
    assign o_occ = (state_reg == FULL) ? 2'd2 :
                   (state_reg == BUSY) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_lix_skid_buf.sv
// Directed checks of lix_skid_buf followed by a random handshake run
// compared against a queue model.
module tb_lix_skid_buf;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         i_flush;
    logic         i_vld;
    logic [W-1:0] i_x;
    logic         o_rdy;
    logic         o_vld;
    logic         i_rdy;
    logic [W-1:0] o_z;
    logic [1:0]   o_occ;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];

    lix_skid_buf #(.W(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_flush(i_flush),
        .i_vld  (i_vld),
        .i_x    (i_x),
        .o_rdy  (o_rdy),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_z    (o_z),
        .o_occ  (o_occ)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic vld, input logic rdy, input logic [1:0] occ);
        chk({tag, ".vld"}, 32'(o_vld), 32'(vld));
        chk({tag, ".rdy"}, 32'(o_rdy), 32'(rdy));
        chk({tag, ".occ"}, 32'(o_occ), 32'(occ));
    endtask

    initial begin
        rst_ni  = 1'b0;
        i_flush = 1'b0;
        i_vld   = 1'b0;
        i_x     = '0;
        i_rdy   = 1'b0;
        #2;
        chk_state("reset", 1'b0, 1'b0, 2'd0);
        chk("reset.z", o_z, 32'h0);
        tick();
        tick();

        // Release; first edge only raises o_rdy even though i_vld is high.
        i_vld  = 1'b1;
        i_x    = 32'hA5A5A5A5;
        i_rdy  = 1'b1;
        rst_ni = 1'b1;
        tick();
        chk_state("release", 1'b0, 1'b1, 2'd0);
        tick();
        chk_state("first_acc", 1'b1, 1'b1, 2'd1);
        chk("first_acc.z", o_z, 32'hA5A5A5A5);
        i_vld = 1'b0;
        tick();
        chk_state("drain1", 1'b0, 1'b1, 2'd0);

        // Full-throughput stream.
        for (int k = 1; k <= 4; k++) begin
            i_vld = 1'b1;
            i_x   = 32'(k);
            tick();
            chk_state($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1);
            chk($sformatf("stream%0d.z", k), o_z, 32'(k));
        end
        i_vld = 1'b0;
        tick();
        chk_state("stream_end", 1'b0, 1'b1, 2'd0);

        // Stall, fill to FULL, offered word refused, then drain in order.
        i_rdy = 1'b0;
        i_vld = 1'b1;
        i_x   = 32'h10;
        tick();
        chk_state("stall1", 1'b1, 1'b1, 2'd1);
        i_x = 32'h11;
        tick();
        chk_state("stall2", 1'b1, 1'b0, 2'd2);
        chk("stall2.z", o_z, 32'h10);
        i_x = 32'h12;
        tick();
        chk_state("stall3", 1'b1, 1'b0, 2'd2);
        chk("stall3.z", o_z, 32'h10);
        i_rdy = 1'b1;
        tick();
        chk_state("unstall1", 1'b1, 1'b1, 2'd1);
        chk("unstall1.z", o_z, 32'h11);
        tick();
        chk_state("unstall2", 1'b1, 1'b1, 2'd1);
        chk("unstall2.z", o_z, 32'h12);
        i_vld = 1'b0;
        tick();
        chk_state("unstall3", 1'b0, 1'b1, 2'd0);

        // Flush from FULL with a concurrent offer.
        i_rdy = 1'b0;
        i_vld = 1'b1;
        i_x   = 32'h20;
        tick();
        i_x = 32'h21;
        tick();
        chk_state("pre_flush", 1'b1, 1'b0, 2'd2);
        i_flush = 1'b1;
        i_x     = 32'h22;
        tick();
        chk_state("flush", 1'b0, 1'b1, 2'd0);
        chk("flush.z_hold", o_z, 32'h20);
        i_flush = 1'b0;
        i_vld   = 1'b0;
        i_rdy   = 1'b1;
        tick();
        chk_state("post_flush", 1'b0, 1'b1, 2'd0);
        i_vld = 1'b1;
        i_x   = 32'h30;
        tick();
        chk_state("after_flush", 1'b1, 1'b1, 2'd1);
        chk("after_flush.z", o_z, 32'h30);
        i_vld = 1'b0;
        tick();

        // Asynchronous reset from FULL.
        i_rdy = 1'b0;
        i_vld = 1'b1;
        i_x   = 32'h40;
        tick();
        i_x = 32'h41;
        tick();
        chk_state("pre_areset", 1'b1, 1'b0, 2'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_state("areset", 1'b0, 1'b0, 2'd0);
        chk("areset.z", o_z, 32'h0);
        i_vld = 1'b0;
        i_x   = '0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk_state("rerelease", 1'b0, 1'b1, 2'd0);

        // Random handshake traffic against a FIFO model of depth two.
        for (int c = 0; c < 3000; c++) begin
            logic acc;
            logic xf;
            i_vld = 1'($urandom_range(0, 1));
            i_rdy = 1'($urandom_range(0, 1));
            i_x   = $urandom;
            acc = i_vld && (q.size() < 2);
            xf  = (q.size() > 0) && i_rdy;
            tick();
            if (xf) void'(q.pop_front());
            if (acc) q.push_back(i_x);
            chk("rnd.occ", 32'(o_occ), 32'(q.size()));
            chk("rnd.rdy", 32'(o_rdy), 32'(q.size() < 2));
            chk("rnd.vld", 32'(o_vld), 32'(q.size() > 0));
            if (q.size() > 0) chk("rnd.z", o_z, q[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
